alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i input 1, rising-edge clock; rst_i input 1, synchronous active-high reset.
REQ-002 SHALL provide: req_valid_i input 1, operation request valid; req_ready_o output 1, block can accept a request.
REQ-003 SHALL provide: ctrl_i input 4, ALU control code from the ALU control stage; src1_i input 32, operand 1 or shift amount; src2_i input 32, operand 2.
REQ-004 SHALL provide: rsp_valid_o output 1, result valid; rsp_ready_i input 1, consumer accepts result.
REQ-005 SHALL provide: result_o output 32, operation result; zero_o output 1, result_o == 0.
REQ-006 SHALL provide busy_o output 1, high while in the SHIFT state (pipeline stall source).

Function
REQ-007 SHALL decode ctrl_i as AND=0, OR=1, NAND=2, NOR=3, ADDU=4, SUBU=5, SLT=6, EQUAL=7, SRA=8, SRAV=9, LUI=10, SLTU=11; codes 12-15 SHALL give result 0.
REQ-008 SHALL compute: ADDU/SUBU mod 2^32, no overflow flag; SLT signed, SLTU unsigned compare, result 1 or 0; EQUAL gives 1 if src1==src2 else 0; LUI gives src2[15:0]<<16.
REQ-009 SHALL treat SRA and SRAV identically: result = src2 arithmetic-shifted right by src1[4:0], with src1[31:5] ignored.
REQ-010 SHALL implement the states IDLE, SHIFT, and RESP.
REQ-011 SHALL drive req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i); a request is accepted when req_valid_i & req_ready_o.
REQ-012 On acceptance of a non-shift op, or a shift with amount 0, SHALL register the result and enter RESP; rsp_valid_o rises the next cycle (latency 1).
REQ-013 On acceptance of a shift with amount N in 1..31, SHALL load src2 and N and enter SHIFT; in SHIFT it SHALL shift 1 bit per cycle, sign-filling and decrementing the counter; when the counter reaches 1, that final shift SHALL occur and the next state SHALL be RESP; rsp_valid_o rises N+1 cycles after acceptance.
REQ-014 In RESP, SHALL hold rsp_valid_o, result_o, and zero_o stable until rsp_ready_i; on rsp_ready_i without a new request, SHALL go to IDLE.
REQ-015 On simultaneous rsp_ready_i and an accepted request in RESP, SHALL complete the handshake and process the new request with no bubble.
REQ-016 SHALL ignore inputs when req_ready_o is low; operands SHALL be captured only at acceptance.
REQ-017 result_o SHALL hold its last value in IDLE; zero_o SHALL always equal (result_o == 0).

Reset
REQ-018 When rst_i is high at a clock edge, SHALL force: state IDLE, rsp_valid_o 0, result_o 0, zero_o 1, busy_o 0, shift counter 0.
REQ-019 A reset during SHIFT or RESP SHALL abandon the operation, and no response SHALL be produced.
REQ-020 req_ready_o SHALL be 1 the first cycle after reset is released.

Structure
REQ-021 The ctrl code constants (REQ-007) and the state encoding SHALL reside in shared package alu_pkg, which the ALU control stage also uses.
REQ-022 Single-cycle operations SHALL be evaluated in combinational sub-module alu_comb (ctrl, src1, src2 -> result); alu_seq SHALL hold the FSM, shift datapath, and handshake.

Verification
REQ-023 ADDU: src1=0xFFFFFFFF, src2=1, rsp_ready_i=1 -> rsp_valid_o the next cycle, result_o=0, zero_o=1.
REQ-024 SLT vs SLTU: src1=0xFFFFFFFF, src2=1 -> SLT gives 1; SLTU gives 0.
REQ-025 SRAV: src1=4, src2=0x80000000 -> busy_o high 4 cycles, rsp_valid_o at cycle 5, result_o=0xF8000000; SRA with amount 0 -> latency 1, result_o=src2.
REQ-026 Backpressure: hold rsp_ready_i=0 for 3 cycles in RESP -> result_o stable and req_ready_o=0; then assert rsp_ready_i with a queued LUI of src2=0x1234 -> accepted the same cycle, next result_o=0x12340000.
REQ-027 Reset mid-shift: SRA by 31 with rst_i asserted at cycle 10 -> next cycle state IDLE, rsp_valid_o=0, zero_o=1, and no response is ever emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and sequencer state encoding
// Shared with the ALU control stage so both sides agree on the code map.
package alu_pkg;

  typedef enum logic [3:0] {
    CTRL_AND  = 4'd0,
    CTRL_OR   = 4'd1,
    CTRL_NAND = 4'd2,
    CTRL_NOR  = 4'd3,
    CTRL_ADDU = 4'd4,
    CTRL_SUBU = 4'd5,
    CTRL_SLT  = 4'd6,
    CTRL_EQ   = 4'd7,
    CTRL_SRA  = 4'd8,
    CTRL_SRAV = 4'd9,
    CTRL_LUI  = 4'd10,
    CTRL_SLTU = 4'd11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } alu_state_e;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == CTRL_SRA) || (ctrl == CTRL_SRAV);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ALU evaluation
// Purely combinational; unused codes 12-15 yield zero.
module alu_comb
  import alu_pkg::*;
(
  input  logic [3:0]        ctrl,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] src2_s;

  assign src2_s = src2;

  always_comb begin
    result = '0;
    case (ctrl)
      CTRL_AND:  result = src1 & src2;
      CTRL_OR:   result = src1 | src2;
      CTRL_NAND: result = ~(src1 & src2);
      CTRL_NOR:  result = ~(src1 | src2);
      CTRL_ADDU: result = src1 + src2;
      CTRL_SUBU: result = src1 - src2;
      CTRL_SLT:  result = {31'd0, $signed(src1) < $signed(src2)};
      CTRL_EQ:   result = {31'd0, src1 == src2};
      CTRL_SRA,
      CTRL_SRAV: result = src2_s >>> src1[SHAMT_W-1:0];
      CTRL_LUI:  result = {src2[15:0], 16'd0};
      CTRL_SLTU: result = {31'd0, src1 < src2};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with a bit-serial arithmetic shifter
// Non-shift ops complete in one cycle; shifts by N take N cycles in SHIFT.
module alu_seq
  import alu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              busy_o
);

  alu_state_e               state;
  logic [DATA_W-1:0]        result_q;
  logic [DATA_W-1:0]        shreg;
  logic [SHAMT_W-1:0]       cnt;
  logic                     rsp_valid_q;
  logic                     busy_q;
  logic [DATA_W-1:0]        comb_result;
  logic [DATA_W-1:0]        shift_next;
  logic                     accept;

  alu_comb u_alu_comb (
    .ctrl   (ctrl_i),
    .src1   (src1_i),
    .src2   (src2_i),
    .result (comb_result)
  );

  assign req_ready_o = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign shift_next  = DATA_W'($signed(shreg) >>> 1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      shreg       <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            // A zero-amount shift is just a copy, so the combinational path serves it.
            if (is_shift(ctrl_i) && (src1_i[SHAMT_W-1:0] != '0)) begin
              shreg       <= src2_i;
              cnt         <= src1_i[SHAMT_W-1:0];
              state       <= ST_SHIFT;
              busy_q      <= 1'b1;
              rsp_valid_q <= 1'b0;
            end else begin
              result_q    <= comb_result;
              state       <= ST_RESP;
              busy_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
            end
          end else if ((state == ST_RESP) && rsp_ready_i) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          shreg <= shift_next;
          cnt   <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            result_q    <= shift_next;
            state       <= ST_RESP;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = busy_q;
  assign result_o    = result_q;
  assign zero_o      = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  ctrl = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  alu_seq dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .ctrl_i      (ctrl),
    .src1_i      (src1),
    .src2_i      (src2),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .result_o    (result),
    .zero_o      (zero),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sb;
    sb = b;
    case (c)
      4'd0:       return a & b;
      4'd1:       return a | b;
      4'd2:       return ~(a & b);
      4'd3:       return ~(a | b);
      4'd4:       return a + b;
      4'd5:       return a - b;
      4'd6:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:       return (a == b) ? 32'd1 : 32'd0;
      4'd8, 4'd9: return sb >>> a[4:0];
      4'd10:      return {b[15:0], 16'h0000};
      4'd11:      return (a < b) ? 32'd1 : 32'd0;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] a);
    if ((c == 4'd8 || c == 4'd9) && a[4:0] != 5'd0) return int'(a[4:0]) + 1;
    return 1;
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    ctrl = c;
    src1 = a;
    src2 = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ctrl = 4'($urandom);
    src1 = $urandom;
    src2 = $urandom;
    lat = 0;
    busy_cyc = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cyc++;
      if (rsp_valid) break;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    vectors++;
    if (result !== 32'd0 || zero !== 1'b1) begin miscompares++; $display("FAIL reset_result: got %h/%b expected 0/1", result, zero); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_directed();
    int lat, bc;
    logic [31:0] b;
    run_op(4'd4, 32'hFFFF_FFFF, 32'd1, lat, bc);
    vectors++;
    if (lat !== 1 || result !== 32'd0 || zero !== 1'b1) begin
      miscompares++; $display("FAIL addu_wrap: lat %0d res %h zero %b expected 1 0 1", lat, result, zero);
    end
    release_rsp();
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, lat, bc);
    vectors++;
    if (result !== 32'd1) begin miscompares++; $display("FAIL slt_signed: got %h expected 1", result); end
    release_rsp();
    run_op(4'd11, 32'hFFFF_FFFF, 32'd1, lat, bc);
    vectors++;
    if (result !== 32'd0 || zero !== 1'b1) begin miscompares++; $display("FAIL sltu_unsigned: got %h expected 0", result); end
    release_rsp();
    run_op(4'd9, 32'd4, 32'h8000_0000, lat, bc);
    vectors++;
    if (bc !== 4 || lat !== 5) begin miscompares++; $display("FAIL srav_timing: busy %0d lat %0d expected 4 5", bc, lat); end
    vectors++;
    if (result !== 32'hF800_0000) begin miscompares++; $display("FAIL srav_result: got %h expected f8000000", result); end
    release_rsp();
    b = $urandom;
    run_op(4'd8, 32'd0, b, lat, bc);
    vectors++;
    if (lat !== 1 || result !== b) begin miscompares++; $display("FAIL sra_zero: lat %0d res %h expected 1 %h", lat, result, b); end
    release_rsp();
    b = 32'h8765_4321;
    run_op(4'd8, 32'hFFFF_FFE3, b, lat, bc);
    vectors++;
    if (lat !== 4 || result !== 32'hF0EC_A864) begin miscompares++; $display("FAIL sra_upper_ignored: lat %0d res %h expected 4 f0eca864", lat, result); end
    release_rsp();
    run_op(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    vectors++;
    if (lat !== 1 || result !== 32'd0) begin miscompares++; $display("FAIL unused_code: lat %0d res %h expected 1 0", lat, result); end
    release_rsp();
  endtask

  task automatic test_random();
    int lat, bc, hold;
    logic [3:0] c;
    logic [31:0] a, b, exp;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a = {a[31:5], 5'(i % 32)};
      if (i % 5 == 0) b = a;
      exp = model(c, a, b);
      run_op(c, a, b, lat, bc);
      vectors++;
      if (lat !== model_lat(c, a)) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, model_lat(c, a)); end
      vectors++;
      if (result !== exp || zero !== (exp == 32'd0)) begin
        miscompares++; $display("FAIL rand_result[%0d] ctrl %0d: got %h/%b expected %h/%b", i, c, result, zero, exp, exp == 32'd0);
      end
      vectors++;
      if (bc !== lat - 1) begin miscompares++; $display("FAIL rand_busy[%0d]: got %0d expected %0d", i, bc, lat - 1); end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        vectors++;
        if (result !== exp || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
          miscompares++; $display("FAIL rand_hold[%0d]: res %h valid %b ready %b expected %h 1 0", i, result, rsp_valid, req_ready, exp);
        end
      end
      release_rsp();
    end
  endtask

  task automatic test_backpressure();
    int lat, bc;
    logic [31:0] a, b, exp;
    a = $urandom;
    b = $urandom;
    exp = a | b;
    run_op(4'd1, a, b, lat, bc);
    req_valid = 1'b1;
    ctrl = 4'd10;
    src1 = $urandom;
    src2 = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (result !== exp || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_stall[%0d]: res %h valid %b ready %b expected %h 1 0", i, result, rsp_valid, req_ready, exp);
      end
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready: got %b expected 1", req_ready); end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1 || result !== 32'h1234_0000 || zero !== 1'b0) begin
      miscompares++; $display("FAIL bp_lui: valid %b res %h expected 1 12340000", rsp_valid, result);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    logic [3:0] c;
    logic [31:0] a, b, exp;
    exp = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (rsp_valid !== 1'b1 || result !== exp || req_ready !== 1'b1) begin
          miscompares++; $display("FAIL b2b[%0d]: valid %b res %h ready %b expected 1 %h 1", i, rsp_valid, result, req_ready, exp);
        end
      end
      if (i < 12) begin
        c = 4'($urandom_range(0, 9));
        if (c >= 4'd8) c = c + 4'd2;
        a = $urandom;
        b = $urandom;
        req_valid = 1'b1;
        ctrl = c;
        src1 = a;
        src2 = b;
        exp = model(c, a, b);
      end else begin
        req_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_drain: valid %b ready %b expected 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic seen;
    @(negedge clk);
    req_valid = 1'b1;
    ctrl = 4'd8;
    src1 = 32'd31;
    src2 = $urandom | 32'h8000_0000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || zero !== 1'b1 || busy !== 1'b0 || result !== 32'd0) begin
      miscompares++; $display("FAIL rst_shift_state: valid %b zero %b busy %b res %h expected 0 1 0 0", rsp_valid, zero, busy, result);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_shift_ready: got %b expected 1", req_ready); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL rst_shift_no_rsp: got %b expected 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
